// File: rtl/spi_word_peripheral.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : spi_word_peripheral
// Purpose  : SPI peripheral moving WORD_BYTES-byte words. Byte order on the
//            wire is little-endian, and bits within each byte go MSB-first.
//            CPOL and CPHA select any of the four SPI modes. SCK, CS and
//            COPI are oversampled in the clk domain.
// Ports    : clk, resetn     - system clock, async active-low reset
//            SCK, CS, COPI   - SPI bus inputs (CS active-low)
//            CIPO            - SPI data out, high-Z outside an active frame
//            tx_word         - next word to send, captured when tx_load=1
//            tx_load         - pulse: tx_word captured into the tx register
//            rx_word         - last completed received word
//            rx_valid        - pulse: rx_word updated
//            frame_abort     - pulse: CS released part-way through a word
//            busy            - a frame is in progress (synchronised CS low)
// Revision : 1.0 - initial release
// ============================================================================
module spi_word_peripheral #(
    parameter int WORD_BYTES  = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    SCK,
    input  logic                    CS,
    input  logic                    COPI,
    output logic                    CIPO,
    input  logic [8*WORD_BYTES-1:0] tx_word,
    output logic                    tx_load,
    output logic [8*WORD_BYTES-1:0] rx_word,
    output logic                    rx_valid,
    output logic                    frame_abort,
    output logic                    busy
);

    localparam int               c_WORD_BITS = 8 * WORD_BYTES;
    localparam int               c_CNT_W     = $clog2(c_WORD_BITS);
    localparam logic             c_CPOL      = (CPOL != 0);
    localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'(c_WORD_BITS - 1);
    // XOR with 7 turns a wire-order bit number into its vector index:
    // the byte stays the same and the bit position within the byte is mirrored.
    localparam logic [c_CNT_W-1:0] c_FLIP    = c_CNT_W'(7);

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_copi_sync;
    logic [SYNC_STAGES-1:0] r_settle;
    logic                   r_sck_hist;
    logic                   r_cs_hist;
    logic                   r_armed;
    logic                   r_in_frame;
    logic                   r_first_shift;
    logic [c_CNT_W-1:0]     r_bit_cnt;
    logic [c_CNT_W-1:0]     r_tx_ptr;
    logic [c_WORD_BITS-1:0] r_tx;
    logic [c_WORD_BITS-1:0] r_rx_shift;
    logic [c_WORD_BITS-1:0] r_rx_word;
    logic                   r_rx_valid;
    logic                   r_frame_abort;

    logic                   w_sck_s;
    logic                   w_cs_s;
    logic                   w_copi_s;
    logic                   w_lead;
    logic                   w_trail;
    logic                   w_sample;
    logic                   w_shift;
    logic                   w_start;
    logic                   w_word_done;
    logic [c_CNT_W-1:0]     w_rx_idx;
    logic [c_CNT_W-1:0]     w_tx_idx;
    logic [c_WORD_BITS-1:0] w_rx_next;

    // ------------------------------------------------------------------
    // Input synchronisers, preset to the idle bus state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sck_sync  <= {SYNC_STAGES{c_CPOL}};
            r_cs_sync   <= '1;
            r_copi_sync <= '0;
            r_sck_hist  <= c_CPOL;
            r_cs_hist   <= 1'b1;
            r_settle    <= '0;
            r_armed     <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], SCK};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], CS};
            r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], COPI};
            r_sck_hist  <= w_sck_s;
            r_cs_hist   <= w_cs_s;
            r_settle    <= {r_settle[SYNC_STAGES-2:0], 1'b1};
            // The preset CS=1 is not a real observation. Arm frame starts
            // only after a genuine high CS has reached the synchroniser
            // output, so a CS that stayed low through reset starts nothing.
            if (w_cs_s && r_settle[SYNC_STAGES-1]) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_sck_s  = r_sck_sync[SYNC_STAGES-1];
    assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
    assign w_copi_s = r_copi_sync[SYNC_STAGES-1];

    assign w_lead   = (w_sck_s != c_CPOL) && (r_sck_hist == c_CPOL);
    assign w_trail  = (w_sck_s == c_CPOL) && (r_sck_hist != c_CPOL);
    assign w_sample = (CPHA != 0) ? w_trail : w_lead;
    assign w_shift  = (CPHA != 0) ? w_lead  : w_trail;

    assign w_start     = r_armed && r_cs_hist && !w_cs_s;
    // When CS rises in the same cycle as the final sample edge, w_cs_s is
    // already high, so the word is never completed. It is reported as an abort.
    assign w_word_done = r_in_frame && !w_cs_s && w_sample && (r_bit_cnt == c_LAST);

    assign w_rx_idx = r_bit_cnt ^ c_FLIP;
    assign w_tx_idx = r_tx_ptr ^ c_FLIP;

    always_comb begin
        w_rx_next           = r_rx_shift;
        w_rx_next[w_rx_idx] = w_copi_s;
    end

    // ------------------------------------------------------------------
    // Frame, shift and word handling
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_in_frame    <= 1'b0;
            r_first_shift <= 1'b0;
            r_bit_cnt     <= '0;
            r_tx_ptr      <= '0;
            r_tx          <= '0;
            r_rx_shift    <= '0;
            r_rx_word     <= '0;
            r_rx_valid    <= 1'b0;
            r_frame_abort <= 1'b0;
        end else begin
            r_rx_valid    <= w_word_done;
            r_frame_abort <= r_in_frame && w_cs_s && (r_bit_cnt != '0);
            if (w_word_done) begin
                r_rx_word <= w_rx_next;
            end

            if (w_start) begin
                r_in_frame    <= 1'b1;
                r_tx          <= tx_word;
                r_bit_cnt     <= '0;
                r_tx_ptr      <= '0;
                r_first_shift <= 1'b1;
            end else if (w_cs_s) begin
                r_in_frame    <= 1'b0;
                r_bit_cnt     <= '0;
                r_tx_ptr      <= '0;
                r_first_shift <= 1'b0;
            end else if (r_in_frame) begin
                if (w_sample) begin
                    r_rx_shift <= w_rx_next;
                    if (r_bit_cnt == c_LAST) begin
                        r_bit_cnt <= '0;
                        r_tx      <= tx_word;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
                    end
                end
                if (w_shift) begin
                    // With CPHA=1, the first leading edge only marks the start
                    // of bit 0, which is already on CIPO.
                    if ((CPHA != 0) && r_first_shift) begin
                        r_first_shift <= 1'b0;
                    end else if (r_tx_ptr == c_LAST) begin
                        r_tx_ptr <= '0;
                    end else begin
                        r_tx_ptr <= r_tx_ptr + c_CNT_W'(1);
                    end
                end
            end
        end
    end

    assign CIPO        = r_in_frame ? r_tx[w_tx_idx] : 1'bz;
    assign tx_load     = w_start || w_word_done;
    assign rx_word     = r_rx_word;
    assign rx_valid    = r_rx_valid;
    assign frame_abort = r_frame_abort;
    // A CS that was already low at reset release has no frame behind it and
    // does not report busy.
    assign busy        = r_in_frame;

endmodule
`default_nettype wire

// File: tb/tb_spi_word_peripheral.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_spi_word_peripheral
// Purpose  : Self-checking bench for spi_word_peripheral. It runs four
//            instances: mode 0 with 8 bytes, mode 3 with 2 bytes, mode 0
//            with 4 bytes, and mode 1 with 1 byte. All four share SCK and
//            COPI, and each has its own CS. The bench holds a word-level
//            model: the words it sends, the words it expects back, and the
//            aborts it expects.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_word_peripheral;

    localparam int c_SYNC = 2;

    typedef struct {
        int           inst;
        logic [127:0] word;
    } rx_t;

    logic        clk;
    logic        resetn;
    logic        sck;
    logic        copi;
    logic [3:0]  cs;
    logic [63:0] txw0;
    logic [15:0] txw1;
    logic [31:0] txw2;
    logic [7:0]  txw3;
    logic [63:0] rx0;
    logic [15:0] rx1;
    logic [31:0] rx2;
    logic [7:0]  rx3;
    wire  [3:0]  cipo;
    wire  [3:0]  cipo_z;
    wire  [3:0]  txl;
    wire  [3:0]  rxv;
    wire  [3:0]  abt;
    wire  [3:0]  bsy;
    logic [127:0] rxw [4];

    int           n_checks;
    int           n_err;
    int           txl_cnt [4];
    int           cs_hi [4];
    rx_t          exp_rx [$];
    int           exp_abort [$];
    logic [127:0] tx_plan [$];
    logic [127:0] mosi_w [0:3];
    logic         cap [0:511];

    spi_word_peripheral #(.WORD_BYTES(8), .CPOL(0), .CPHA(0), .SYNC_STAGES(c_SYNC)) u0 (
        .clk(clk), .resetn(resetn), .SCK(sck), .CS(cs[0]), .COPI(copi), .CIPO(cipo[0]),
        .tx_word(txw0), .tx_load(txl[0]), .rx_word(rx0), .rx_valid(rxv[0]),
        .frame_abort(abt[0]), .busy(bsy[0]));
    spi_word_peripheral #(.WORD_BYTES(2), .CPOL(1), .CPHA(1), .SYNC_STAGES(c_SYNC)) u1 (
        .clk(clk), .resetn(resetn), .SCK(sck), .CS(cs[1]), .COPI(copi), .CIPO(cipo[1]),
        .tx_word(txw1), .tx_load(txl[1]), .rx_word(rx1), .rx_valid(rxv[1]),
        .frame_abort(abt[1]), .busy(bsy[1]));
    spi_word_peripheral #(.WORD_BYTES(4), .CPOL(0), .CPHA(0), .SYNC_STAGES(c_SYNC)) u2 (
        .clk(clk), .resetn(resetn), .SCK(sck), .CS(cs[2]), .COPI(copi), .CIPO(cipo[2]),
        .tx_word(txw2), .tx_load(txl[2]), .rx_word(rx2), .rx_valid(rxv[2]),
        .frame_abort(abt[2]), .busy(bsy[2]));
    spi_word_peripheral #(.WORD_BYTES(1), .CPOL(0), .CPHA(1), .SYNC_STAGES(c_SYNC)) u3 (
        .clk(clk), .resetn(resetn), .SCK(sck), .CS(cs[3]), .COPI(copi), .CIPO(cipo[3]),
        .tx_word(txw3), .tx_load(txl[3]), .rx_word(rx3), .rx_valid(rxv[3]),
        .frame_abort(abt[3]), .busy(bsy[3]));

    assign rxw[0] = 128'(rx0);
    assign rxw[1] = 128'(rx1);
    assign rxw[2] = 128'(rx2);
    assign rxw[3] = 128'(rx3);
    assign cipo_z[0] = (cipo[0] === 1'bz);
    assign cipo_z[1] = (cipo[1] === 1'bz);
    assign cipo_z[2] = (cipo[2] === 1'bz);
    assign cipo_z[3] = (cipo[3] === 1'bz);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic check_z(input string name, input logic isz, input logic act);
        n_checks++;
        if (!isz) begin
            n_err++;
            $display("FAIL %s: actual %b required z", name, act);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_tx(input int inst, input logic [127:0] v);
        case (inst)
            0:       txw0 = v[63:0];
            1:       txw1 = v[15:0];
            2:       txw2 = v[31:0];
            default: txw3 = v[7:0];
        endcase
    endtask

    // Bit i of a word on the wire: byte i/8 goes out MSB-first.
    function automatic logic wire_bit(input logic [127:0] w, input int i);
        logic [7:0] byte_v;
        byte_v = w[8*(i/8) +: 8];
        return byte_v[7 - (i % 8)];
    endfunction

    function automatic logic [7:0] cap_byte(input int base);
        logic [7:0] v;
        for (int j = 0; j < 8; j++) v[7-j] = cap[base+j];
        return v;
    endfunction

    function automatic logic [127:0] cap_word(input int base, input int nbytes);
        logic [127:0] v;
        v = '0;
        for (int k = 0; k < nbytes; k++) v[8*k +: 8] = cap_byte(base + 8*k);
        return v;
    endfunction

    // This is the controller side. It sends nbits of mosi_w as words of
    // wbits each and records CIPO in cap[] at the controller's sample points.
    // After CS falls and after each completed word, it presents the next
    // tx_plan entry.
    task automatic frame(input int inst, input int cpol, input int cpha, input int hp,
                         input int wbits, input int nbits, input bit do_fall, input bit do_rise);
        logic idle;
        logic b;
        idle = (cpol != 0);
        sck  = idle;
        wait_clk(6);
        if (do_fall) begin
            cs[inst] = 1'b0;
            wait_clk(2*hp);
            if (tx_plan.size() > 0) set_tx(inst, tx_plan.pop_front());
        end
        for (int i = 0; i < nbits; i++) begin
            b = wire_bit(mosi_w[i / wbits], i % wbits);
            if (cpha == 0) begin
                copi = b;
                wait_clk(hp);
                cap[i] = cipo[inst];
                sck = ~idle;
                wait_clk(hp);
                sck = idle;
            end else begin
                sck  = ~idle;
                copi = b;
                wait_clk(hp);
                cap[i] = cipo[inst];
                sck = idle;
                wait_clk(hp);
            end
            if ((i % wbits == wbits - 1) && (tx_plan.size() > 0))
                set_tx(inst, tx_plan.pop_front());
        end
        wait_clk(hp);
        if (do_rise) begin
            cs[inst] = 1'b1;
            wait_clk(2*hp + 4);
        end
    endtask

    // This block runs every cycle. It checks rx_valid and frame_abort
    // against the model queues, makes sure each is a one-cycle pulse, counts
    // tx_load pulses, and confirms that CIPO is high-Z once CS has been idle.
    initial begin
        logic [3:0] prev_v;
        logic [3:0] prev_a;
        rx_t        e;
        prev_v = '0;
        prev_a = '0;
        for (int i = 0; i < 4; i++) begin
            txl_cnt[i] = 0;
            cs_hi[i]   = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (rxv[i]) begin
                    check("rx_valid_width", 128'(prev_v[i]), 128'(0));
                    if (exp_rx.size() == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL rx_unexpected: inst %0d actual %h required none", i, rxw[i]);
                    end else begin
                        e = exp_rx.pop_front();
                        check("rx_inst", 128'(i), 128'(e.inst));
                        check("rx_word", rxw[i], e.word);
                    end
                end
                if (abt[i]) begin
                    check("abort_width", 128'(prev_a[i]), 128'(0));
                    if (exp_abort.size() == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL abort_unexpected: inst %0d actual 1 required 0", i);
                    end else begin
                        check("abort_inst", 128'(i), 128'(exp_abort.pop_front()));
                    end
                end
                if (txl[i]) txl_cnt[i]++;
                cs_hi[i] = cs[i] ? cs_hi[i] + 1 : 0;
                if (cs_hi[i] >= 6) check_z("cipo_idle_z", cipo_z[i], cipo[i]);
            end
            prev_v = rxv;
            prev_a = abt;
        end
    end

    initial begin
        rx_t r;
        int  t;
        n_checks = 0;
        n_err    = 0;
        resetn   = 1'b0;
        cs       = 4'hF;
        sck      = 1'b0;
        copi     = 1'b0;
        txw0 = '0; txw1 = '0; txw2 = '0; txw3 = '0;
        for (int i = 0; i < 4; i++) mosi_w[i] = '0;
        wait_clk(5);
        check("reset_rx_word", rxw[0], 128'(0));
        check("reset_pulses", 128'({rxv, txl, abt, bsy}), 128'(0));
        check_z("reset_cipo_z", cipo_z[0], cipo[0]);
        resetn = 1'b1;
        wait_clk(5);

        // Test 1: mode 0, 64-bit word
        mosi_w[0] = 128'(64'hFEDCBA9876543210);
        set_tx(0, 128'(64'h0123456789ABCDEF));
        r.inst = 0; r.word = mosi_w[0]; exp_rx.push_back(r);
        t = txl_cnt[0];
        frame(0, 0, 0, 4, 64, 64, 1'b1, 1'b1);
        check("t1_miso_word", cap_word(0, 8), 128'(64'h0123456789ABCDEF));
        check("t1_miso_byte0", 128'(cap_byte(0)), 128'(8'hEF));
        check("t1_miso_byte7", 128'(cap_byte(56)), 128'(8'h01));
        check("t1_rx_word", rxw[0], 128'(64'hFEDCBA9876543210));
        check("t1_tx_loads", 128'(txl_cnt[0] - t), 128'(2));

        // Test 2: mode 3, 16-bit word
        mosi_w[0] = 128'(16'h1234);
        set_tx(1, 128'(16'hA55A));
        r.inst = 1; r.word = mosi_w[0]; exp_rx.push_back(r);
        t = txl_cnt[1];
        frame(1, 1, 1, 4, 16, 16, 1'b1, 1'b1);
        check("t2_miso_byte0", 128'(cap_byte(0)), 128'(8'h5A));
        check("t2_miso_byte1", 128'(cap_byte(8)), 128'(8'hA5));
        check("t2_rx_word", rxw[1], 128'(16'h1234));
        check("t2_tx_loads", 128'(txl_cnt[1] - t), 128'(2));
        sck = 1'b0;

        // Test 3: three back-to-back 32-bit words in one frame
        mosi_w[0] = 128'(32'h11111111);
        mosi_w[1] = 128'(32'h22222222);
        mosi_w[2] = 128'(32'h33333333);
        for (int k = 0; k < 3; k++) begin
            r.inst = 2; r.word = mosi_w[k]; exp_rx.push_back(r);
        end
        set_tx(2, 128'(32'hA0A00001));
        tx_plan.push_back(128'(32'hB0B00002));
        tx_plan.push_back(128'(32'hC0C00003));
        tx_plan.push_back(128'(32'hD0D00004));
        t = txl_cnt[2];
        frame(2, 0, 0, 4, 32, 96, 1'b1, 1'b1);
        check("t3_miso_w0", cap_word(0, 4), 128'(32'hA0A00001));
        check("t3_miso_w1", cap_word(32, 4), 128'(32'hB0B00002));
        check("t3_miso_w2", cap_word(64, 4), 128'(32'hC0C00003));
        check("t3_tx_loads", 128'(txl_cnt[2] - t), 128'(4));
        check("t3_rx_pending", 128'(exp_rx.size()), 128'(0));

        // Test 4: abort after 13 bits, then a clean word
        mosi_w[0] = 128'(32'hDEADBEEF);
        exp_abort.push_back(2);
        t = txl_cnt[2];
        frame(2, 0, 0, 4, 32, 13, 1'b1, 1'b1);
        check("t4_abort_seen", 128'(exp_abort.size()), 128'(0));
        check("t4_rx_kept", rxw[2], 128'(32'h33333333));
        check("t4_tx_loads", 128'(txl_cnt[2] - t), 128'(1));
        mosi_w[0] = 128'(32'h5A5AC3C3);
        set_tx(2, 128'(32'h0F0F1234));
        r.inst = 2; r.word = mosi_w[0]; exp_rx.push_back(r);
        frame(2, 0, 0, 4, 32, 32, 1'b1, 1'b1);
        check("t4_rx_next", rxw[2], 128'(32'h5A5AC3C3));
        check("t4_miso_next", cap_word(0, 4), 128'(32'h0F0F1234));

        // Test 5: reset mid-word with CS held low
        mosi_w[0] = 128'(32'hCAFEF00D);
        frame(2, 0, 0, 4, 32, 10, 1'b1, 1'b0);
        resetn = 1'b0;
        #1;
        check("t5_rst_rx_word", rxw[2], 128'(0));
        check("t5_rst_pulses", 128'({rxv[2], txl[2], abt[2], bsy[2]}), 128'(0));
        check_z("t5_rst_cipo_z", cipo_z[2], cipo[2]);
        wait_clk(3);
        resetn = 1'b1;
        wait_clk(4);
        t = txl_cnt[2];
        frame(2, 0, 0, 4, 32, 32, 1'b0, 1'b0);
        check("t5_no_busy", 128'(bsy[2]), 128'(0));
        check("t5_no_load", 128'(txl_cnt[2] - t), 128'(0));
        check("t5_rx_still0", rxw[2], 128'(0));
        cs[2] = 1'b1;
        wait_clk(12);
        mosi_w[0] = 128'(32'h600DCAFE);
        set_tx(2, 128'(32'h13579BDF));
        r.inst = 2; r.word = mosi_w[0]; exp_rx.push_back(r);
        frame(2, 0, 0, 4, 32, 32, 1'b1, 1'b1);
        check("t5_rx_after", rxw[2], 128'(32'h600DCAFE));
        check("t5_miso_after", cap_word(0, 4), 128'(32'h13579BDF));

        // Test 6: mode 1, minimum SCK half-period, one byte
        mosi_w[0] = 128'(8'h3C);
        set_tx(3, 128'(8'hC3));
        r.inst = 3; r.word = mosi_w[0]; exp_rx.push_back(r);
        frame(3, 0, 1, c_SYNC + 1, 8, 8, 1'b1, 1'b1);
        check("t6_miso_byte", 128'(cap_byte(0)), 128'(8'hC3));
        check("t6_rx_word", rxw[3], 128'(8'h3C));
        check_z("t6_cipo_z", cipo_z[3], cipo[3]);

        wait_clk(4);
        check("rx_queue_empty", 128'(exp_rx.size()), 128'(0));
        check("abort_queue_empty", 128'(exp_abort.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
